// File: rtl/scalar_result_sequencer_pkg.sv
// Shared types and constants for the scalar result sequencer: unit class
// encodings, write-slot entry layout and opcode (octal gh) range bounds.
package scalar_result_sequencer_pkg;

  typedef enum logic [1:0] {
    UNIT_LOGICAL = 2'd0,
    UNIT_SHIFT   = 2'd1,
    UNIT_ADD     = 2'd2,
    UNIT_POP     = 2'd3
  } unit_e;

  // NONE lives outside the 2-bit slot encoding; slots carry only real units.
  typedef enum logic [2:0] {
    CLS_LOGICAL = 3'd0,
    CLS_SHIFT   = 3'd1,
    CLS_ADD     = 3'd2,
    CLS_POP     = 3'd3,
    CLS_NONE    = 3'd4
  } cls_e;

  localparam int unsigned REG_W  = 3;
  localparam int unsigned UNIT_W = 2;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  dest;
    unit_e             unit;
  } slot_t;

  localparam logic [6:0] OP_LOGICAL_LO = 7'o042;
  localparam logic [6:0] OP_LOGICAL_HI = 7'o051;
  localparam logic [6:0] OP_LOG_CHK_LO = 7'o044;
  localparam logic [6:0] OP_SHIFT_LO   = 7'o052;
  localparam logic [6:0] OP_SHIFT_HI   = 7'o057;
  localparam logic [6:0] OP_SHF_CHK_LO = 7'o056;
  localparam logic [6:0] OP_ADD_LO     = 7'o060;
  localparam logic [6:0] OP_ADD_HI     = 7'o061;
  localparam logic [6:0] OP_POP_LO     = 7'o026;
  localparam logic [6:0] OP_POP_HI     = 7'o027;

  function automatic logic in_range(input logic [6:0] op, input logic [6:0] lo,
                                    input logic [6:0] hi);
    return (op >= lo) && (op <= hi);
  endfunction

endpackage

// File: rtl/scalar_result_sequencer_decode.sv
// Combinational opcode decode: unit class, issue-to-result latency and
// which of the j/k fields name source registers.
module scalar_class_decode
  import scalar_result_sequencer_pkg::*;
#(
  parameter int unsigned LAT_W       = 3,
  parameter int unsigned LAT_LOGICAL = 1,
  parameter int unsigned LAT_SHIFT   = 2,
  parameter int unsigned LAT_ADD     = 3,
  parameter int unsigned LAT_POP     = 4
) (
  input  logic [6:0]       instr,
  output cls_e             cls,
  output logic [LAT_W-1:0] lat,
  output logic             j_chk,
  output logic             k_chk
);

  always_comb begin
    cls   = CLS_NONE;
    lat   = '0;
    j_chk = 1'b0;
    k_chk = 1'b0;
    if (in_range(instr, OP_LOGICAL_LO, OP_LOGICAL_HI)) begin
      cls   = CLS_LOGICAL;
      lat   = LAT_W'(LAT_LOGICAL);
      j_chk = in_range(instr, OP_LOG_CHK_LO, OP_LOGICAL_HI);
      k_chk = j_chk;
    end else if (in_range(instr, OP_SHIFT_LO, OP_SHIFT_HI)) begin
      cls   = CLS_SHIFT;
      lat   = LAT_W'(LAT_SHIFT);
      j_chk = in_range(instr, OP_SHF_CHK_LO, OP_SHIFT_HI);
      k_chk = j_chk;
    end else if (in_range(instr, OP_ADD_LO, OP_ADD_HI)) begin
      cls   = CLS_ADD;
      lat   = LAT_W'(LAT_ADD);
      j_chk = 1'b1;
      k_chk = 1'b1;
    end else if (in_range(instr, OP_POP_LO, OP_POP_HI)) begin
      cls   = CLS_POP;
      lat   = LAT_W'(LAT_POP);
      j_chk = 1'b1;
    end
  end

endmodule

// File: rtl/scalar_result_sequencer.sv
// Scalar issue interlock, S write-port slot booking and result steering.
// Optional hold-cycle counter enabled by SCALAR_HOLD_COUNT_EN.
module scalar_result_sequencer
  import scalar_result_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LAT     = 8,
  parameter int unsigned LAT_LOGICAL = 1,
  parameter int unsigned LAT_SHIFT   = 2,
  parameter int unsigned LAT_ADD     = 3,
  parameter int unsigned LAT_POP     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_issue,
  input  logic [6:0]  i_instr,
  input  logic [2:0]  i_i,
  input  logic [2:0]  i_j,
  input  logic [2:0]  i_k,
  input  logic [63:0] i_logical_result,
  input  logic [63:0] i_shift_result,
  input  logic [63:0] i_add_result,
  input  logic [63:0] i_pop_result,
  output logic        o_hold,
  output logic        o_s_we,
  output logic [2:0]  o_s_addr,
  output logic [63:0] o_s_data,
  output logic [7:0]  o_s_res,
  output logic [31:0] o_hold_cycles
);

  localparam int unsigned LAT_W = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  cls_e             cls;
  logic [LAT_W-1:0] lat;
  logic             j_chk;
  logic             k_chk;
  logic             accept;
  logic [7:0]       res_next;
  slot_t            slot [MAX_LAT];

  scalar_class_decode #(
    .LAT_W       (LAT_W),
    .LAT_LOGICAL (LAT_LOGICAL),
    .LAT_SHIFT   (LAT_SHIFT),
    .LAT_ADD     (LAT_ADD),
    .LAT_POP     (LAT_POP)
  ) u_decode (
    .instr (i_instr),
    .cls   (cls),
    .lat   (lat),
    .j_chk (j_chk),
    .k_chk (k_chk)
  );

  always_comb begin
    o_hold = 1'b0;
    if (i_issue && (cls != CLS_NONE)) begin
      o_hold = o_s_res[i_i]
             | (j_chk && (i_j != '0) && o_s_res[i_j])
             | (k_chk && (i_k != '0) && o_s_res[i_k])
             | slot[lat].valid;
    end
    accept = i_issue && (cls != CLS_NONE) && !o_hold;
  end

  // Clear of the retiring dest and set of a new dest may hit different bits in one edge.
  always_comb begin
    res_next = o_s_res;
    if (slot[0].valid) res_next[slot[0].dest] = 1'b0;
    if (accept)        res_next[i_i]          = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned d = 0; d < MAX_LAT; d++) slot[d] <= '0;
      o_s_res <= '0;
    end else begin
      for (int unsigned d = 0; d + 1 < MAX_LAT; d++) slot[d] <= slot[d+1];
      slot[MAX_LAT-1] <= '0;
      if (accept) slot[lat - 1'b1] <= '{valid: 1'b1, dest: i_i, unit: unit_e'(cls[1:0])};
      o_s_res <= res_next;
    end
  end

  always_comb begin
    o_s_we   = slot[0].valid;
    o_s_addr = '0;
    o_s_data = '0;
    if (slot[0].valid) begin
      o_s_addr = slot[0].dest;
      unique case (slot[0].unit)
        UNIT_LOGICAL: o_s_data = i_logical_result;
        UNIT_SHIFT:   o_s_data = i_shift_result;
        UNIT_ADD:     o_s_data = i_add_result;
        UNIT_POP:     o_s_data = i_pop_result;
      endcase
    end
  end

`ifdef SCALAR_HOLD_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_hold_cycles <= '0;
    end else if (i_issue && o_hold && (o_hold_cycles != '1)) begin
      o_hold_cycles <= o_hold_cycles + 32'd1;
    end
  end
`else
  assign o_hold_cycles = '0;
`endif

endmodule

// File: tb/tb_scalar_result_sequencer.sv
// Directed self-checking bench for scalar_result_sequencer.
module tb_scalar_result_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_issue;
  logic [6:0]  i_instr;
  logic [2:0]  i_i, i_j, i_k;
  logic [63:0] i_logical_result, i_shift_result, i_add_result, i_pop_result;
  logic        o_hold, o_s_we;
  logic [2:0]  o_s_addr;
  logic [63:0] o_s_data;
  logic [7:0]  o_s_res;
  logic [31:0] o_hold_cycles;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] LOG_V = 64'h00FF_00FF_00FF_00FF;
  localparam logic [63:0] SHF_V = 64'h1111_2222_3333_4444;
  localparam logic [63:0] ADD_V = 64'hA5A5_0000_5A5A_FFFF;
  localparam logic [63:0] POP_V = 64'h0000_0000_0000_0040;

  scalar_result_sequencer #(
    .MAX_LAT     (8),
    .LAT_LOGICAL (1),
    .LAT_SHIFT   (2),
    .LAT_ADD     (3),
    .LAT_POP     (4)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_issue          (i_issue),
    .i_instr          (i_instr),
    .i_i              (i_i),
    .i_j              (i_j),
    .i_k              (i_k),
    .i_logical_result (i_logical_result),
    .i_shift_result   (i_shift_result),
    .i_add_result     (i_add_result),
    .i_pop_result     (i_pop_result),
    .o_hold           (o_hold),
    .o_s_we           (o_s_we),
    .o_s_addr         (o_s_addr),
    .o_s_data         (o_s_data),
    .o_s_res          (o_s_res),
    .o_hold_cycles    (o_hold_cycles)
  );

  always #5 clk = ~clk;

  // Each cycle: inputs change 2 time units after the rising edge, checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic iss, input logic [6:0] op, input logic [2:0] i,
                       input logic [2:0] j, input logic [2:0] k);
    i_issue = iss; i_instr = op; i_i = i; i_j = j; i_k = k;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 7'o000, 3'd0, 3'd0, 3'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic check_write(input string name, input logic we, input logic [2:0] addr,
                             input logic [63:0] data);
    checks++;
    if (o_s_we !== we || o_s_addr !== addr || o_s_data !== data) begin
      errors++;
      $display("FAIL %s: we/addr/data got %b/%0d/%h expected %b/%0d/%h",
               name, o_s_we, o_s_addr, o_s_data, we, addr, data);
    end
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    check_write("reset_outputs", 1'b0, 3'd0, 64'd0);
    checks++;
    if (o_s_res !== 8'h00 || o_hold !== 1'b0 || o_hold_cycles !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: res/hold/cnt got %h/%b/%0d expected 00/0/0",
               o_s_res, o_hold, o_hold_cycles);
    end
  endtask

  task automatic test_logical();
    tick(); drive(1'b1, 7'o044, 3'd3, 3'd1, 3'd2);
    checks++;
    if (o_hold !== 1'b0) begin errors++; $display("FAIL logical_issue_hold: got %b expected 0", o_hold); end
    tick(); idle();
    check_write("logical_write", 1'b1, 3'd3, LOG_V);
    checks++;
    if (o_s_res !== 8'h08) begin errors++; $display("FAIL logical_res_set: got %h expected 08", o_s_res); end
    tick(); idle();
    check_write("logical_after", 1'b0, 3'd0, 64'd0);
    checks++;
    if (o_s_res !== 8'h00) begin errors++; $display("FAIL logical_res_clr: got %h expected 00", o_s_res); end
  endtask

  task automatic test_dependency();
    tick(); drive(1'b1, 7'o060, 3'd2, 3'd0, 3'd0);
    for (int c = 1; c <= 3; c++) begin
      tick(); drive(1'b1, 7'o044, 3'd5, 3'd2, 3'd1);
      checks++;
      if (o_hold !== 1'b1) begin errors++; $display("FAIL dep_hold_T%0d: got %b expected 1", c, o_hold); end
      if (c == 3) check_write("dep_add_write", 1'b1, 3'd2, ADD_V);
    end
    tick(); drive(1'b1, 7'o044, 3'd5, 3'd2, 3'd1);
    checks++;
    if (o_hold !== 1'b0) begin errors++; $display("FAIL dep_accept: hold got %b expected 0", o_hold); end
    tick(); idle();
    check_write("dep_logical_write", 1'b1, 3'd5, LOG_V);
    tick(); idle();
  endtask

  task automatic test_back_to_back();
    tick(); drive(1'b1, 7'o060, 3'd1, 3'd0, 3'd0);
    tick(); drive(1'b1, 7'o052, 3'd4, 3'd0, 3'd0);
    checks++;
    if (o_hold !== 1'b1) begin errors++; $display("FAIL port_collision_hold: got %b expected 1", o_hold); end
    tick(); drive(1'b1, 7'o052, 3'd4, 3'd0, 3'd0);
    checks++;
    if (o_hold !== 1'b0) begin errors++; $display("FAIL port_collision_accept: hold got %b expected 0", o_hold); end
    tick(); idle();
    check_write("collision_add_write", 1'b1, 3'd1, ADD_V);
    tick(); idle();
    check_write("collision_shift_write", 1'b1, 3'd4, SHF_V);
    tick(); idle();
    check_write("collision_drained", 1'b0, 3'd0, 64'd0);
  endtask

  task automatic test_zero_src();
    tick(); drive(1'b1, 7'o061, 3'd0, 3'd0, 3'd0);
    tick(); drive(1'b1, 7'o044, 3'd6, 3'd0, 3'd0);
    checks++;
    if (o_hold !== 1'b0 || o_s_res !== 8'h01) begin
      errors++;
      $display("FAIL zero_src_hold: hold/res got %b/%h expected 0/01", o_hold, o_s_res);
    end
    tick(); drive(1'b1, 7'o070, 3'd0, 3'd0, 3'd0);
    check_write("zero_src_write", 1'b1, 3'd6, LOG_V);
    checks++;
    if (o_hold !== 1'b0) begin errors++; $display("FAIL none_class_hold: got %b expected 0", o_hold); end
    tick(); idle();
    check_write("s0_add_write", 1'b1, 3'd0, ADD_V);
    tick(); idle();
    checks++;
    if (o_s_we !== 1'b0 || o_s_res !== 8'h00) begin
      errors++;
      $display("FAIL none_class_books: we/res got %b/%h expected 0/00", o_s_we, o_s_res);
    end
  endtask

  task automatic test_reset_inflight();
    tick(); drive(1'b1, 7'o026, 3'd7, 3'd0, 3'd0);
    tick(); idle();
    checks++;
    if (o_s_res !== 8'h80) begin errors++; $display("FAIL pop_res_set: got %h expected 80", o_s_res); end
    tick(); rst_n = 1'b0; idle();
    tick(); rst_n = 1'b1; idle();
    checks++;
    if (o_s_res !== 8'h00) begin errors++; $display("FAIL inflight_res_clr: got %h expected 00", o_s_res); end
    for (int c = 0; c < 4; c++) begin
      check_write("inflight_dropped", 1'b0, 3'd0, 64'd0);
      tick(); idle();
    end
  endtask

  task automatic test_hold_count();
    logic [31:0] exp_cnt;
`ifdef SCALAR_HOLD_COUNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    do_reset();
    tick(); drive(1'b1, 7'o060, 3'd2, 3'd0, 3'd0);
    for (int c = 0; c < 3; c++) begin
      tick(); drive(1'b1, 7'o044, 3'd5, 3'd2, 3'd0);
    end
    tick(); idle();
    checks++;
    if (o_hold_cycles !== exp_cnt) begin
      errors++;
      $display("FAIL hold_count: got %0d expected %0d", o_hold_cycles, exp_cnt);
    end
    tick(); tick(); idle();
  endtask

  initial begin
    i_logical_result = LOG_V;
    i_shift_result   = SHF_V;
    i_add_result     = ADD_V;
    i_pop_result     = POP_V;
    rst_n = 1'b0;
    idle();
    test_reset();
    test_logical();
    test_dependency();
    test_back_to_back();
    test_zero_src();
    test_reset_inflight();
    test_hold_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scalar_result_sequencer.md
Name: scalar_result_sequencer

Overview:
Issue-side and result-side counterpart to the scalar logical/shift/add/pop functional units. Tracks S-register reservations, decides whether a scalar instruction may issue, books the single S-register write port for the cycle the unit's result arrives, and steers that unit's result into the S register file. Sits between the instruction issue stage and the S register file write port.

Parameters:
MAX_LAT, 8, depth of the write-slot pipeline; every latency below must be 1..MAX_LAT-1
LAT_LOGICAL, 1, cycles from issue to result for 042-051
LAT_SHIFT, 2, cycles from issue to result for 052-057
LAT_ADD, 3, cycles from issue to result for 060-061
LAT_POP, 4, cycles from issue to result for 026-027

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
i_issue  in  1  instruction presented for issue this cycle
i_instr  in  7  opcode gh field (octal 0gh)
i_i  in  3  destination S register
i_j  in  3  j field
i_k  in  3  k field
i_logical_result  in  64  logical unit result
i_shift_result  in  64  shift unit result
i_add_result  in  64  scalar add unit result
i_pop_result  in  64  pop/leading-zero unit result
o_hold  out  1  issue refused this cycle (combinational)
o_s_we  out  1  S register write enable
o_s_addr  out  3  S register write address
o_s_data  out  64  S register write data
o_s_res  out  8  per-register reservation bits
o_hold_cycles  out  32  hold counter (optional feature)

Behaviour:
- Reset (rst_n=0 at an edge): all slots invalid, o_s_res=0, counter=0; in-flight results dropped. Outputs then: o_s_we=0, o_s_addr=0, o_s_data=0.
- Class decode: 042-051 LOGICAL; 052-057 SHIFT; 060-061 ADD; 026-027 POP. Any other opcode is NONE: never holds, books nothing.
- Source checks: j checked if j!=0 for 044-051, 056-057, 060-061, 026-027; k checked if k!=0 for 044-051, 056-057, 060-061. Opcodes 042/043/052-055 have no j/k source check. j=0/k=0 never create dependency.
- Slot pipeline slot[0..MAX_LAT-1], each {valid, dest[2:0], class[1:0]}; slot[d] writes d cycles from now. Each edge: slot[d-1]<=slot[d], slot[MAX_LAT-1]<=invalid.
- o_hold = i_issue & class!=NONE & (o_s_res[i] | checked source reserved | slot[L].valid), L = class latency.
- Accept = i_issue & !o_hold & class!=NONE: at the edge slot[L-1]<={1,i,class}, o_s_res[i]<=1.
- Write: o_s_we=slot[0].valid; o_s_addr=slot[0].dest; o_s_data=result bus selected by slot[0].class; when slot[0] invalid, o_s_addr=0 and o_s_data=0. Issue at cycle T, latency L -> write in cycle T+L.
- Reservation for dest cleared at the edge ending its write cycle; an instruction touching that register issues no earlier than T+L+1 (no bypass).
- Simultaneous write-cycle and accept to the same register cannot occur (the reservation holds issue); clear and set of different bits in one edge both take effect.
- At most one write per cycle guaranteed by the slot check.

Optional Feature:
SCALAR_HOLD_COUNT_EN: defined -> o_hold_cycles increments on every cycle with i_issue&o_hold, saturates at 0xFFFFFFFF, cleared by reset. Undefined -> counter absent, o_hold_cycles tied to 0.

Decomposition:
- Shared package/header: class encoding constants (NONE, LOGICAL, SHIFT, ADD, POP), slot entry layout widths, opcode range constants.
- One sub-module natural: scalar_class_decode (combinational opcode -> class, latency, j/k-check flags).

Test Plan:
- 044 i=3 j=1 k=2 issued at T, i_logical_result=0x00FF00FF00FF00FF -> T+1: o_s_we=1, o_s_addr=3, o_s_data=0x00FF00FF00FF00FF; o_s_res[3]=1 during T+1, 0 at T+2.
- 060 i=2 at T; 044 i=5 j=2 k=1 from T+1 -> o_hold=1 at T+1..T+3, accepted T+4, write at T+5 addr 5.
- Port collision: 060 i=1 at T (write T+3), 052 i=4 at T+1 (L=2) -> hold at T+1, accepted T+2, writes at T+3 (addr 1) and T+4 (addr 4), never both.
- 044 i=6 j=0 k=0 while S0 reserved -> no hold, write at T+1 addr 6.
- 026 i=7 issued at T, rst_n=0 at T+2 -> no write ever occurs, o_s_res=0 from T+3.
- SCALAR_HOLD_COUNT_EN defined, 3 held issue cycles -> o_hold_cycles=3; undefined -> stays 0.
